// File: rtl/dl_serializer.sv
// Downlink serializer: wraps one encoded frame in guard bits and a preamble, shifts it out MSB first.
// Latency: dl_en and the first bit appear in the cycle after the accepting edge; every bit lasts BIT_DIV cycles.
// Backpressure: frame_ready is high only while idle; abort or rst ends a frame on the next edge.
module dl_serializer #(
    parameter int               DATA_W      = 16,
    parameter int               CRC_W       = 8,
    parameter int               PRE_W       = 8,
    parameter logic [PRE_W-1:0] PRE_PATTERN = 8'hA5,
    parameter int               GUARD_BITS  = 2,
    parameter int               BIT_DIV     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] frame_data,
    input  logic [CRC_W-1:0]  frame_crc,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic              abort,
    output logic              dl_out,
    output logic              dl_en,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_aborted
);

    localparam int SH_W  = PRE_W + DATA_W + CRC_W;
    localparam int CNT_W = $clog2(SH_W + GUARD_BITS + 1);
    localparam int DIV_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;

    generate
        if (BIT_DIV < 2) begin : g_bad_div
            $error("dl_serializer: BIT_DIV must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        PRE   = 3'd2,
        DATA  = 3'd3,
        CRC   = 3'd4,
        TRAIL = 3'd5
    } state_t;

    state_t            state, state_nxt, follow_st;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_nxt;
    logic [SH_W-1:0]   shreg, sh_nxt;
    logic              last_bit, shifting, wrap;
    logic              done_nxt, aborted_nxt, dl_out_nxt;

    assign wrap = (div_cnt == DIV_W'(BIT_DIV - 1));

    // Per-state bit budget and successor; guard states carry zeros, the rest shift the frame register.
    always_comb begin
        last_bit  = 1'b0;
        follow_st = IDLE;
        shifting  = 1'b0;
        case (state)
            LEAD: begin
                last_bit  = (bit_cnt == CNT_W'(GUARD_BITS - 1));
                follow_st = PRE;
            end
            PRE: begin
                last_bit  = (bit_cnt == CNT_W'(PRE_W - 1));
                follow_st = DATA;
                shifting  = 1'b1;
            end
            DATA: begin
                last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
                follow_st = CRC;
                shifting  = 1'b1;
            end
            CRC: begin
                last_bit  = (bit_cnt == CNT_W'(CRC_W - 1));
                follow_st = (GUARD_BITS > 0) ? TRAIL : IDLE;
                shifting  = 1'b1;
            end
            TRAIL: begin
                last_bit  = (bit_cnt == CNT_W'(GUARD_BITS - 1));
                follow_st = IDLE;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        bit_nxt     = bit_cnt;
        sh_nxt      = shreg;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        if (state == IDLE) begin
            if (frame_valid && frame_ready) begin
                state_nxt = (GUARD_BITS > 0) ? LEAD : PRE;
                div_nxt   = '0;
                bit_nxt   = '0;
                sh_nxt    = {PRE_PATTERN, frame_data, frame_crc};
            end
        end else if (abort) begin
            // Abort outranks a completing final bit.
            state_nxt   = IDLE;
            div_nxt     = '0;
            bit_nxt     = '0;
            aborted_nxt = 1'b1;
        end else if (wrap) begin
            div_nxt = '0;
            if (shifting) begin
                sh_nxt = shreg << 1;
            end
            if (last_bit) begin
                bit_nxt   = '0;
                state_nxt = follow_st;
                done_nxt  = (follow_st == IDLE);
            end else begin
                bit_nxt = bit_cnt + CNT_W'(1);
            end
        end else begin
            div_nxt = div_cnt + DIV_W'(1);
        end
        dl_out_nxt = (state_nxt inside {PRE, DATA, CRC}) && sh_nxt[SH_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            frame_ready   <= 1'b0;
            dl_out        <= 1'b0;
            dl_en         <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_aborted <= 1'b0;
        end else begin
            state         <= state_nxt;
            div_cnt       <= div_nxt;
            bit_cnt       <= bit_nxt;
            shreg         <= sh_nxt;
            frame_ready   <= (state_nxt == IDLE);
            dl_out        <= dl_out_nxt;
            dl_en         <= (state_nxt != IDLE);
            busy          <= (state_nxt != IDLE);
            frame_done    <= done_nxt;
            frame_aborted <= aborted_nxt;
        end
    end

endmodule

// File: tb/tb_dl_serializer.sv
// Bench for dl_serializer: default instance plus a BIT_DIV=2, GUARD_BITS=0 instance.
// Expected bit streams are queued at handshake time and popped mid-bit while dl_en is high.
module tb_dl_serializer;

    logic        clk;
    logic        rst, frame_valid, frame_ready, abort;
    logic [15:0] frame_data;
    logic [7:0]  frame_crc;
    logic        dl_out, dl_en, busy, frame_done, frame_aborted;

    logic        b_rst, b_frame_valid, b_frame_ready, b_abort;
    logic [15:0] b_frame_data;
    logic [7:0]  b_frame_crc;
    logic        b_dl_out, b_dl_en, b_busy, b_frame_done, b_frame_aborted;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        exp_q[$];

    dl_serializer u_dut (
        .clk(clk), .rst(rst), .frame_data(frame_data), .frame_crc(frame_crc),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .abort(abort),
        .dl_out(dl_out), .dl_en(dl_en), .busy(busy),
        .frame_done(frame_done), .frame_aborted(frame_aborted)
    );

    dl_serializer #(.BIT_DIV(2), .GUARD_BITS(0)) u_dut_fast (
        .clk(clk), .rst(b_rst), .frame_data(b_frame_data), .frame_crc(b_frame_crc),
        .frame_valid(b_frame_valid), .frame_ready(b_frame_ready), .abort(b_abort),
        .dl_out(b_dl_out), .dl_en(b_dl_en), .busy(b_busy),
        .frame_done(b_frame_done), .frame_aborted(b_frame_aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [7:0] c, input int guard);
        logic [7:0] pre;
        pre = 8'hA5;
        for (int i = 0; i < guard; i++) exp_q.push_back(1'b0);
        for (int i = 7; i >= 0; i--) exp_q.push_back(pre[i]);
        for (int i = 15; i >= 0; i--) exp_q.push_back(d[i]);
        for (int i = 7; i >= 0; i--) exp_q.push_back(c[i]);
        for (int i = 0; i < guard; i++) exp_q.push_back(1'b0);
    endtask

    // Called #1 after the accepting edge; returns #1 after the edge where dl_en falls.
    task automatic collect_frame(output int en_cycles, output logic done_seen, output int ready_bad);
        logic exp;
        en_cycles = 0;
        ready_bad = 0;
        while (dl_en === 1'b1 && en_cycles < 400) begin
            if (en_cycles % 8 == 4) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bit_%0d: got %b, scoreboard empty", en_cycles / 8, dl_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (dl_out !== exp) begin
                        n_fail++;
                        $display("FAIL bit_%0d: got %b, expected %b", en_cycles / 8, dl_out, exp);
                    end
                end
            end
            if (frame_ready !== 1'b0) ready_bad++;
            en_cycles++;
            tick();
        end
        done_seen = frame_done;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_valid = 1'b0; abort = 1'b0; frame_data = '0; frame_crc = '0;
        b_rst = 1'b1; b_frame_valid = 1'b0; b_abort = 1'b0; b_frame_data = '0; b_frame_crc = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({frame_ready, dl_out, dl_en, busy, frame_done, frame_aborted} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b, expected 000000",
                         {frame_ready, dl_out, dl_en, busy, frame_done, frame_aborted});
            end
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 1", frame_ready);
        end
        repeat (4) tick();
        n_tests++;
        if (dl_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: dl_en=%b busy=%b, expected 0 0", dl_en, busy);
        end
    endtask

    task automatic test_single();
        int en; logic dn; int rb;
        frame_data = 16'hC3A1; frame_crc = 8'h5E; frame_valid = 1'b1;
        push_frame(16'hC3A1, 8'h5E, 2);
        tick();
        frame_valid = 1'b0;
        collect_frame(en, dn, rb);
        n_tests++;
        if (en != 288) begin
            n_fail++;
            $display("FAIL single_len: dl_en high %0d cycles, expected 288", en);
        end
        n_tests++;
        if (dn !== 1'b1 || frame_aborted !== 1'b0 || frame_ready !== 1'b1 || dl_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: done=%b aborted=%b ready=%b dl_out=%b, expected 1 0 1 0",
                     dn, frame_aborted, frame_ready, dl_out);
        end
        tick();
        n_tests++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: frame_done=%b one cycle later, expected 0", frame_done);
        end
    endtask

    task automatic test_back_to_back();
        int en; logic dn; int rb; int t1; int t2;
        frame_data = 16'h0001; frame_crc = 8'h01; frame_valid = 1'b1;
        push_frame(16'h0001, 8'h01, 2);
        tick();
        frame_data = 16'h8000; frame_crc = 8'h80;
        push_frame(16'h8000, 8'h80, 2);
        collect_frame(en, dn, rb);
        t1 = cyc;
        n_tests++;
        if (dn !== 1'b1 || en != 288) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b len=%0d, expected 1 288", dn, en);
        end
        tick();
        n_tests++;
        if (dl_en !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: dl_en=%b after one low cycle, expected 1", dl_en);
        end
        frame_valid = 1'b0;
        collect_frame(en, dn, rb);
        t2 = cyc;
        n_tests++;
        if (dn !== 1'b1 || (t2 - t1) != 289) begin
            n_fail++;
            $display("FAIL b2b_spacing: done=%b spacing=%0d, expected 1 289", dn, t2 - t1);
        end
        tick();
    endtask

    task automatic test_stability();
        int en; logic dn; int rb;
        frame_data = 16'h1234; frame_crc = 8'h77; frame_valid = 1'b1;
        push_frame(16'h1234, 8'h77, 2);
        tick();
        frame_data = 16'hFFFF;
        collect_frame(en, dn, rb);
        frame_valid = 1'b0;
        n_tests++;
        if (rb != 0 || en != 288) begin
            n_fail++;
            $display("FAIL stable_ready: ready high %0d busy cycles, len=%0d, expected 0 288", rb, en);
        end
        tick();
    endtask

    task automatic test_abort();
        frame_data = 16'hC3A1; frame_crc = 8'h5E; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (14 * 8 + 3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if ({dl_en, dl_out, frame_aborted, frame_done, frame_ready, busy} !== 6'b001010) begin
            n_fail++;
            $display("FAIL abort_mid: en,out,abt,done,rdy,busy=%b, expected 001010",
                     {dl_en, dl_out, frame_aborted, frame_done, frame_ready, busy});
        end
        tick();
        n_tests++;
        if (frame_aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pulse: frame_aborted=%b, expected 0", frame_aborted);
        end
        abort = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (frame_aborted !== 1'b0 || frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle: aborted=%b ready=%b, expected 0 1", frame_aborted, frame_ready);
        end
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        abort = 1'b0;
        n_tests++;
        if (dl_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle_accept: dl_en=%b, expected 1", dl_en);
        end
        repeat (287) tick();
        n_tests++;
        if (dl_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_last_pre: dl_en=%b before last edge, expected 1", dl_en);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if ({dl_en, frame_aborted, frame_done} !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_last_wrap: en,abt,done=%b, expected 010", {dl_en, frame_aborted, frame_done});
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        frame_data = 16'hBEEF; frame_crc = 8'h42; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (2 * 8 + 12) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({dl_en, dl_out, frame_done, frame_aborted, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid: en,out,done,abt,busy=%b, expected 00000",
                     {dl_en, dl_out, frame_done, frame_aborted, busy});
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (frame_ready !== 1'b1 || frame_done !== 1'b0 || frame_aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: ready=%b done=%b aborted=%b, expected 1 0 0",
                     frame_ready, frame_done, frame_aborted);
        end
    endtask

    task automatic test_override();
        int en;
        logic exp;
        exp_q.delete();
        b_rst = 1'b0;
        tick();
        b_frame_data = 16'hC3A1; b_frame_crc = 8'h5E; b_frame_valid = 1'b1;
        push_frame(16'hC3A1, 8'h5E, 0);
        tick();
        b_frame_valid = 1'b0;
        n_tests++;
        if (b_dl_en !== 1'b1 || b_dl_out !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_start: dl_en=%b dl_out=%b, expected 1 1", b_dl_en, b_dl_out);
        end
        en = 0;
        while (b_dl_en === 1'b1 && en < 200) begin
            if (en % 2 == 1) begin
                n_tests++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                if (b_dl_out !== exp) begin
                    n_fail++;
                    $display("FAIL fast_bit_%0d: got %b, expected %b", en / 2, b_dl_out, exp);
                end
            end
            en++;
            tick();
        end
        n_tests++;
        if (en != 64 || b_frame_done !== 1'b1 || b_frame_aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_end: len=%0d done=%b aborted=%b, expected 64 1 0",
                     en, b_frame_done, b_frame_aborted);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stability();
        test_abort();
        test_reset_mid_frame();
        test_override();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d bits left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_serializer.md
Name: dl_serializer

Overview:
Downlink transmit stage that sits directly downstream of the FEC encoder (CPC + CRC) inside fec_top. It accepts one encoded frame (payload plus CRC) over a valid/ready handshake, then serialises it onto dl_out at a programmable bit rate. The frame is wrapped in guard bits and a preamble. dl_en is asserted for the whole frame so the ASK RF module keys its carrier only while the frame is on air.

Parameters:
DATA_W, 16, encoded payload width in bits (CPC output)
CRC_W, 8, CRC field width in bits
PRE_W, 8, preamble width in bits
PRE_PATTERN, 8'hA5, preamble value, transmitted MSB first
GUARD_BITS, 2, number of zero bits sent with dl_en=1 before the preamble and after the CRC
BIT_DIV, 8, clk cycles per transmitted bit; must be >= 2 (elaboration-time $error otherwise)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
frame_data  input  DATA_W  encoded payload, MSB transmitted first
frame_crc  input  CRC_W  CRC of payload, MSB transmitted first
frame_valid  input  1  encoder presents a frame
frame_ready  output  1  serializer can accept a frame
abort  input  1  terminate the current frame immediately
dl_out  output  1  serial bit to ASK modulator
dl_en  output  1  carrier enable to ASK modulator
busy  output  1  a frame is in progress (state != IDLE)
frame_done  output  1  one-cycle pulse when a frame completes normally
frame_aborted  output  1  one-cycle pulse when a frame is terminated by abort

Behaviour:
- The design uses a single clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, frame_ready=0 during the rst cycle and 1 on the first cycle after rst deasserts. dl_out=0, dl_en=0, busy=0, frame_done=0, frame_aborted=0. Bit and divider counters are 0.
- Reset mid-frame: on the next edge, dl_en=0 and dl_out=0. No frame_done or frame_aborted pulse is generated.
- frame_ready=1 only in IDLE. The handshake completes when frame_valid && frame_ready on a rising edge. On that edge, frame_data and frame_crc are latched into a shift register of width PRE_W+DATA_W+CRC_W, together with PRE_PATTERN.
- Inputs are ignored outside IDLE. Changes to frame_data or frame_valid while busy have no effect.
- FSM states: IDLE -> LEAD -> PRE -> DATA -> CRC -> TRAIL -> IDLE.
  - LEAD: GUARD_BITS zero bits.
  - PRE: PRE_W bits.
  - DATA: DATA_W bits.
  - CRC: CRC_W bits.
  - TRAIL: GUARD_BITS zero bits.
  - If GUARD_BITS=0, LEAD and TRAIL are skipped.
- Latency: the handshake occurs at edge N. dl_en=1 and the first bit are driven from edge N+1.
- Each bit is held for exactly BIT_DIV cycles. A divider counter runs from 0 to BIT_DIV-1, and the shift or next bit occurs on wrap.
- Frame length is 2*GUARD_BITS+PRE_W+DATA_W+CRC_W bits. With defaults this is 36 bits, which is 288 cycles of dl_en=1.
- End of frame: after the last TRAIL bit completes, the FSM returns to IDLE.
  - On that edge: dl_en=0, dl_out=0, busy=0, frame_ready=1, and frame_done=1 for one cycle.
- Back-to-back frames: if frame_valid is held high, the next handshake occurs on the first IDLE cycle. dl_en is therefore low for exactly 1 cycle between frames.
- dl_out is 0 whenever dl_en=0. dl_en never toggles within a frame.
- abort:
  - Sampled in any non-IDLE state. On the next edge: IDLE, dl_en=0, dl_out=0, frame_aborted=1 for one cycle, frame_done=0, frame_ready=1.
  - abort in IDLE is ignored; no pulse is generated.
  - If abort is asserted in the same cycle as the final bit wrap, abort wins: frame_aborted=1 and frame_done=0.
  - If abort and frame_valid are both high in IDLE, the frame is accepted.
- frame_done and frame_aborted are never high in the same cycle.

Test Plan:
1. Reset release: rst=1 for 3 cycles, then 0 -> every output is 0 while rst=1; frame_ready=1 on the first cycle after release; dl_en stays 0 with no valid.
2. Single default frame: data=16'hC3A1, crc=8'h5E, valid pulsed once -> dl_en high for 288 cycles starting at handshake+1. Sampled bits (every 8 cycles) are 00, A5, C3A1, 5E, 00, all MSB first. frame_done pulses 1 cycle as dl_en falls.
3. Back-to-back: valid held high with two frames, 16'h0001/8'h01 then 16'h8000/8'h80 -> exactly 1 low cycle of dl_en between the frames; two frame_done pulses 289 cycles apart.
4. Input stability: change frame_data to 16'hFFFF mid-frame and hold valid high -> transmitted payload is still the latched value; frame_ready stays 0 until the frame ends.
5. Abort mid-DATA: assert abort at bit 14 -> next edge dl_en=0, dl_out=0, frame_aborted=1, frame_done=0, frame_ready=1. Abort on the final-bit wrap cycle -> frame_aborted only.
6. Reset mid-frame, then parameter override BIT_DIV=2, GUARD_BITS=0: rst during PRE -> outputs 0 next edge with no pulses. Next frame -> dl_en high for 64 cycles, A5 begins immediately.
